// File: rtl/spi_ram_if.sv
// ---------------------------------------------------------------------------
// spi_ram_if - command/response bundle between the SPI slave front-end
// (master modport) and the command-decoded RAM slave (slave modport).
//
//   din       [PAYLOAD_W+1:PAYLOAD_W] opcode, [PAYLOAD_W-1:0] payload
//   rx_valid  din carries a command this cycle
//   tx_ready  consumer accepts dout this cycle
//   dout      read data
//   tx_valid  dout valid, held until tx_valid & tx_ready
//   busy      a read is in flight or awaiting handshake
//   err_addr  sticky: out-of-range address command rejected
//   err_ovr   sticky: read-data command dropped while busy
// ---------------------------------------------------------------------------
interface spi_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int PAYLOAD_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic [PAYLOAD_W+1:0] din;
  logic                 rx_valid;
  logic                 tx_ready;
  logic [DATA_W-1:0]    dout;
  logic                 tx_valid;
  logic                 busy;
  logic                 err_addr;
  logic                 err_ovr;

  modport master (
    output din, rx_valid, tx_ready,
    input  dout, tx_valid, busy, err_addr, err_ovr
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output dout, tx_valid, busy, err_addr, err_ovr
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl - command-decoded single-port RAM slave behind the SPI
// front-end. Opcodes: 00 set write address, 01 write data, 10 set read
// address, 11 read data. Read data is returned on dout with a
// tx_valid/tx_ready handshake after RD_LATENCY (1 or 2) edges.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    spi_ram_if.slave (din/rx_valid in, dout/tx_valid/busy/errors out)
//
// Parameters: DATA_W, ADDR_W, DEPTH (1 < DEPTH <= 2**ADDR_W),
//             AUTO_INC (post-increment addresses), RD_LATENCY (1 or 2).
// ---------------------------------------------------------------------------
module spi_ram_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int AUTO_INC   = 0,
  parameter int RD_LATENCY = 1
) (
  input logic      clk,
  input logic      rst_n,
  spi_ram_if.slave bus
);

  localparam int PAYLOAD_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_PIPE = 2'd1;
  localparam logic [1:0] S_RD_HOLD = 2'd2;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] stage;
  logic [DATA_W-1:0] dout_q;
  logic              tx_valid_q;
  logic              err_addr_q;
  logic              err_ovr_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // Command field decode; payload bits above ADDR_W/DATA_W are ignored.
  logic [1:0]        op;
  logic [ADDR_W-1:0] pay_addr;
  logic [DATA_W-1:0] pay_data;
  logic              addr_ok;
  logic              handshake;
  logic              rd_cmd;
  logic              rd_accept;

  assign op        = bus.din[PAYLOAD_W+1:PAYLOAD_W];
  assign pay_addr  = bus.din[ADDR_W-1:0];
  assign pay_data  = bus.din[DATA_W-1:0];
  assign addr_ok   = ({1'b0, pay_addr} < DEPTH_L);
  assign handshake = (state == S_RD_HOLD) && bus.tx_ready;
  assign rd_cmd    = bus.rx_valid && (op == OP_RD_DATA);
  // A read is taken when idle, or on the very edge the held data is handed off.
  assign rd_accept = rd_cmd && ((state == S_IDLE) || handshake);

  function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] a);
    return (a == LAST_L) ? '0 : a + 1'b1;
  endfunction

  // NOTE: RAM array has no reset so it maps onto block RAM; its contents are
  // undefined until written.
  always_ff @(posedge clk) begin
    if (bus.rx_valid && (op == OP_WR_DATA))
      mem[wr_addr] <= pay_data;
  end

  // NOTE: all state uses non-blocking assignments, so the read capture below
  // sees the pre-edge RAM contents (read-before-write on a shared edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      stage      <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_addr_q <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      // Address/write commands are legal in any state.
      if (bus.rx_valid) begin
        case (op)
          OP_WR_ADDR: begin
            if (addr_ok) wr_addr <= pay_addr;
            else         err_addr_q <= 1'b1;
          end
          OP_WR_DATA: begin
            if (AUTO_INC != 0) wr_addr <= inc_wrap(wr_addr);
          end
          OP_RD_ADDR: begin
            if (addr_ok) rd_addr <= pay_addr;
            else         err_addr_q <= 1'b1;
          end
          default: begin
            if (rd_accept) begin
              if (AUTO_INC != 0) rd_addr <= inc_wrap(rd_addr);
            end else begin
              err_ovr_q <= 1'b1;
            end
          end
        endcase
      end

      // Read pipeline.
      if (state == S_RD_PIPE) begin
        dout_q     <= stage;
        tx_valid_q <= 1'b1;
        state      <= S_RD_HOLD;
      end else if (rd_accept) begin
        if (RD_LATENCY == 1) begin
          dout_q     <= mem[rd_addr];
          tx_valid_q <= 1'b1;
          state      <= S_RD_HOLD;
        end else begin
          stage      <= mem[rd_addr];
          tx_valid_q <= 1'b0;
          state      <= S_RD_PIPE;
        end
      end else if (handshake) begin
        tx_valid_q <= 1'b0;
        state      <= S_IDLE;
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.err_addr = err_addr_q;
  assign bus.err_ovr  = err_ovr_q;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Parametrised, command-decoded single-port RAM slave that sits behind the SPI slave front-end.
- Receives {opcode, payload} words on din/rx_valid. Opcodes: set write address, write data, set read address, read data.
- Adds configurable data/address widths and depth, optional address auto-increment, 1- or 2-cycle read latency, a tx_valid/tx_ready output handshake, and sticky error flags.

Parameters:
- DATA_W, 8, memory word width and dout width.
- ADDR_W, 8, address register width.
- DEPTH, 256, number of words; must satisfy 1 < DEPTH <= 2**ADDR_W.
- AUTO_INC, 0, 1 = post-increment the write address after write-data and the read address after an accepted read-data.
- RD_LATENCY, 1, 1 or 2: edges from an accepted read-data command to tx_valid high.
- Derived localparam PAYLOAD_W = max(ADDR_W, DATA_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  PAYLOAD_W+2  [PAYLOAD_W+1:PAYLOAD_W] = opcode, [PAYLOAD_W-1:0] = payload.
- rx_valid  in  1  din valid this cycle; one command per asserted cycle.
- tx_ready  in  1  consumer accepts dout when tx_valid & tx_ready.
- dout  out  DATA_W  read data.
- tx_valid  out  1  dout valid; held until handshake.
- busy  out  1  a read is in the pipeline or awaiting handshake.
- err_addr  out  1  sticky: address payload >= DEPTH was rejected.
- err_ovr  out  1  sticky: read-data dropped because the block was busy.

Behaviour:
- Reset (async): dout=0, tx_valid=0, busy=0, err_addr=0, err_ovr=0, wr_addr=0, rd_addr=0, state=IDLE. Memory contents are not reset.
- Commands act only when rx_valid=1 at a rising edge.
- Opcode 00: wr_addr <= payload[ADDR_W-1:0].
- Opcode 01: mem[wr_addr] <= payload[DATA_W-1:0]. If AUTO_INC, wr_addr <= (wr_addr==DEPTH-1) ? 0 : wr_addr+1.
- Opcode 10: rd_addr <= payload[ADDR_W-1:0].
- Opcode 11: read request, accepted per the FSM rules below.
- Address range check: if payload[ADDR_W-1:0] >= DEPTH on 00/10, the address register is unchanged and err_addr <= 1.
- Upper payload bits beyond ADDR_W/DATA_W are ignored.
- FSM states: IDLE, RD_PIPE (present only when RD_LATENCY=2), RD_HOLD.
- IDLE + accepted read: mem[rd_addr] is captured.
  - RD_LATENCY=1: captured into dout; go to RD_HOLD, tx_valid=1 after that edge.
  - RD_LATENCY=2: captured into a stage register; go to RD_PIPE; next edge dout <= stage, go to RD_HOLD, tx_valid=1.
- RD_HOLD: dout and tx_valid are stable until an edge with tx_ready=1; then tx_valid <= 0 and state <= IDLE.
- Back-to-back read: if a read-data command arrives on the same edge as the RD_HOLD handshake, it is accepted.
  - RD_LATENCY=1: dout updates and tx_valid stays 1.
  - RD_LATENCY=2: go to RD_PIPE and tx_valid drops for one cycle.
- Read-data in RD_PIPE, or in RD_HOLD without tx_ready: dropped, err_ovr <= 1, rd_addr unchanged.
- busy = (state != IDLE).
- With tx_ready tied 1: tx_valid is a one-cycle pulse per read in IDLE.
- Address auto-increment on read happens only for accepted reads; wrap DEPTH-1 -> 0.
- Write and read on the same edge to the same address: read returns the OLD data.
- Writes and address commands are legal in any state, including while busy; they do not disturb the pending dout.
- dout keeps its last value after a handshake; it is never cleared except by reset.
- Error flags clear only on reset.
- Reset mid-read: pipeline aborts and all outputs return to reset values immediately (asynchronous).

Test Plan:
- Reset, then 00_0x05, 01_0xA5, 10_0x05, 11_xx with tx_ready=1 and RD_LATENCY=1 -> tx_valid high exactly one cycle, one edge after the 11 command, dout=0xA5.
- RD_LATENCY=2, tx_ready=0 for 3 cycles after tx_valid, then 1 -> tx_valid first high two edges after 11; dout=0xA5 held stable throughout; tx_valid falls after the ready edge.
- AUTO_INC=1, DEPTH=256: 00_0xFF, then 01 with 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22. Read from 0xFF twice -> 0x11 then 0x22; rd_addr wraps to 0x00 then 0x01.
- DEPTH=200: 00_0xC8 -> err_addr=1, wr_addr unchanged. Subsequent 01 writes to the old address.
- tx_ready=0, second 11 while RD_HOLD -> err_ovr=1, dout unchanged. Then assert tx_ready together with a new 11 (RD_LATENCY=1) -> accepted back-to-back, tx_valid stays 1, dout = new data.
- 11 issued, then rst_n pulsed low before tx_valid (RD_LATENCY=2) -> tx_valid, busy and dout immediately 0; no tx_valid after reset release.
